// File: rtl/compare_n_bit_seq.sv
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands CHUNK bits
// per clock, MSB chunk first, stopping at the first differing chunk.
module compare_n_bit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 signed_mode,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 eq,
  output logic                                 gt,
  output logic                                 lt,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]     cycles
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                  state, state_n;
  logic [IW-1:0]               idx, idx_n;
  logic [N-1:0][CHUNK-1:0]     op_a, op_a_n;
  logic [N-1:0][CHUNK-1:0]     op_b, op_b_n;
  logic                        busy_n, done_n, eq_n, gt_n, lt_n;
  logic [CW-1:0]               cycles_n;
  logic [CHUNK-1:0]            chunk_a, chunk_b;
  logic [WIDTH-1:0]            sign_flip;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_flip = {signed_mode, (WIDTH-1)'(0)};
  assign chunk_a   = op_a[idx];
  assign chunk_b   = op_b[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      cycles <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      busy   <= busy_n;
      done   <= done_n;
      eq     <= eq_n;
      gt     <= gt_n;
      lt     <= lt_n;
      cycles <= cycles_n;
    end
  end

  // Next-state and registered-output logic; results hold until next completion.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    op_a_n   = op_a;
    op_b_n   = op_b;
    busy_n   = busy;
    done_n   = 1'b0;
    eq_n     = eq;
    gt_n     = gt;
    lt_n     = lt;
    cycles_n = cycles;
    case (state)
      IDLE: begin
        if (start) begin
          op_a_n  = a ^ sign_flip;
          op_b_n  = b ^ sign_flip;
          idx_n   = IW'(N - 1);
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (chunk_a != chunk_b) begin
          eq_n     = 1'b0;
          gt_n     = (chunk_a > chunk_b);
          lt_n     = (chunk_a < chunk_b);
          cycles_n = CW'(N) - CW'(idx);
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else if (idx == '0) begin
          eq_n     = 1'b1;
          gt_n     = 1'b0;
          lt_n     = 1'b0;
          cycles_n = CW'(N);
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_compare_n_bit_seq.sv
// Self-checking bench for compare_n_bit_seq (WIDTH=8, CHUNK=2): directed table,
// hand-written multi-cycle sequences and randomized compares against a model.
module tb_compare_n_bit_seq;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, signed_mode;
  logic [7:0] a, b;
  logic       busy, done, eq, gt, lt;
  logic [2:0] cycles;

  int checks = 0;
  int failures = 0;

  compare_n_bit_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic       eq;
    logic       gt;
    logic       lt;
    int         cyc;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: numeric compare plus position of the most significant differing bit.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic sm,
                                output logic e, output logic g, output logic l,
                                output int cyc);
    int va, vb, p;
    logic [7:0] x;
    va = sm ? int'($signed(ma)) : int'(ma);
    vb = sm ? int'($signed(mb)) : int'(mb);
    e = (va == vb);
    g = (va > vb);
    l = (va < vb);
    x = ma ^ mb;
    cyc = N;
    p = -1;
    for (int i = 0; i < W; i++) if (x[i]) p = i;
    if (p >= 0) cyc = N - p / C;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or timeout).
  task automatic run_one(input logic [7:0] ra, input logic [7:0] rb, input logic sm,
                         input logic e, input logic g, input logic l, input int cyc,
                         input string tag);
    int n;
    start = 1'b1; a = ra; b = rb; signed_mode = sm;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      chk({tag, "_busy_done_excl"}, int'(busy & done), 0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, cyc);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_eq"}, int'(eq), int'(e));
    chk({tag, "_gt"}, int'(gt), int'(g));
    chk({tag, "_lt"}, int'(lt), int'(l));
    chk({tag, "_cycles"}, int'(cycles), cyc);
  endtask

  vec_t tbl[9];

  initial begin
    logic e, g, l;
    int cyc, n;
    logic [7:0] ra, rb;
    logic rsm;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    tbl[1] = '{8'h11, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[2] = '{8'd100, 8'd99, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[3] = '{8'd135, 8'd130, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{8'hF5, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[5] = '{8'hF5, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[6] = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[8] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 4};

    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({eq, gt, lt}), 0);
    chk("rst_cycles", int'(cycles), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back in each done cycle.
    foreach (tbl[i])
      run_one(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].eq, tbl[i].gt, tbl[i].lt,
              tbl[i].cyc, $sformatf("tbl%0d", i));
    @(negedge clk);
    chk("done_single_pulse", int'(done), 0);
    chk("flags_hold_eq", int'(eq), 0);
    chk("flags_hold_gt", int'(gt), 1);
    chk("cycles_hold", int'(cycles), 4);

    // Start while busy is ignored.
    start = 1'b1; a = 8'd123; b = 8'd125; signed_mode = 1'b0;
    @(negedge clk);
    a = 8'd245; b = 8'd246; signed_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ign_no_done_yet", int'(done), 0);
    @(negedge clk);
    chk("ign_done", int'(done), 1);
    chk("ign_lt", int'(lt), 1);
    chk("ign_gt", int'(gt), 0);
    chk("ign_cycles", int'(cycles), 3);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(done) + int'(busy);
    end
    chk("ign_single_done", n, 0);

    // Reset mid-compare aborts with no done.
    start = 1'b1; a = 8'hAA; b = 8'hAA; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outputs", int'({done, eq, gt, lt, cycles}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(done) + int'(busy);
    end
    chk("abort_no_done", n, 0);
    run_one(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 4, "after_rst");

    // Randomized compares against the reference model.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rsm = 1'($urandom);
      case ($urandom_range(0, 2))
        0: rb = 8'($urandom);
        1: rb = ra;
        default: rb = ra ^ (8'h01 << $urandom_range(0, 7));
      endcase
      model(ra, rb, rsm, e, g, l, cyc);
      run_one(ra, rb, rsm, e, g, l, cyc, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
